// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM state codes and redirect kinds.
// Kept in one place so the control state machine can decode the same values.
package cpu_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  typedef enum logic [1:0] {
    REDIR_BRANCH = 2'b00,
    REDIR_JUMP   = 2'b01,
    REDIR_JR     = 2'b10,
    REDIR_RSVD   = 2'b11
  } redir_kind_e;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/ack bus between the fetch stage and external memory.
interface fetch_stage_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/branch_target_calc.sv
// Combinational next-PC calculation for branch, jump and jump-register redirects.
module branch_target_calc
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       kind,
  input  logic [WIDTH-1:0] pc,
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] reg_target,
  output logic [WIDTH-1:0] target
);

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] branch_offset;
  logic [WIDTH-1:0] jump_target;

  assign pc_plus4      = pc + WIDTH'(4);
  assign branch_offset = {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  // Jump keeps the upper region bits of the delay-slot PC, not of pc itself.
  assign jump_target   = {pc_plus4[WIDTH-1:28], imm, 2'b00};

  always_comb begin
    target = reg_target;
    case (redir_kind_e'(kind))
      REDIR_BRANCH: target = pc_plus4 + branch_offset;
      REDIR_JUMP:   target = jump_target;
      default:      target = reg_target;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch stage with redirect handling, drain of
// in-flight accesses after a redirect, and a sticky ack timeout.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  fetch_stage_if.master    imem,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [1:0]       redir_kind,
  input  logic [WIDTH-1:0] redir_pc,
  input  logic [25:0]      redir_imm,
  input  logic [WIDTH-1:0] redir_reg,
  output logic             fetch_err
);

  logic [1:0]        state_reg;
  logic [WIDTH-1:0]  pc_reg;
  logic [WIDTH-1:0]  drain_addr_reg;
  logic [31:0]       instr_reg;
  logic [WIDTH-1:0]  instr_pc_reg;
  logic              instr_valid_reg;
  logic              fetch_err_reg;
  logic              run_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WIDTH-1:0]  target;
  logic              timeout_hit;

  branch_target_calc #(.WIDTH(WIDTH)) u_target (
    .kind       (redir_kind),
    .pc         (redir_pc),
    .imm        (redir_imm),
    .reg_target (redir_reg),
    .target     (target)
  );

  assign timeout_hit = (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

  // run_reg keeps the request low through the deassertion cycle so a late ack
  // for a pre-reset access is never mistaken for a new one.
  assign imem.imem_req  = run_reg && ((state_reg == ST_FETCH) || (state_reg == ST_DRAIN));
  // While draining, pc_reg already holds the redirect target; the bus keeps the old address.
  assign imem.imem_addr = (state_reg == ST_DRAIN) ? drain_addr_reg : pc_reg;

  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign fetch_err   = fetch_err_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_FETCH;
      pc_reg          <= RESET_PC;
      drain_addr_reg  <= '0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      fetch_err_reg   <= 1'b0;
      wait_cnt_reg    <= '0;
      run_reg         <= 1'b0;
    end else if (!run_reg) begin
      run_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (imem.imem_ack) begin
            wait_cnt_reg <= '0;
            if (redirect) begin
              pc_reg <= target;
            end else begin
              instr_reg       <= imem.imem_rdata;
              instr_pc_reg    <= pc_reg;
              instr_valid_reg <= 1'b1;
              pc_reg          <= pc_reg + WIDTH'(4);
              state_reg       <= ST_HOLD;
            end
          end else if (timeout_hit) begin
            state_reg       <= ST_ERR;
            fetch_err_reg   <= 1'b1;
            instr_valid_reg <= 1'b0;
          end else if (redirect) begin
            drain_addr_reg <= pc_reg;
            pc_reg         <= target;
            wait_cnt_reg   <= '0;
            state_reg      <= ST_DRAIN;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (redirect) begin
            pc_reg <= target;
          end
          if (imem.imem_ack) begin
            wait_cnt_reg <= '0;
            state_reg    <= ST_FETCH;
          end else if (timeout_hit) begin
            state_reg       <= ST_ERR;
            fetch_err_reg   <= 1'b1;
            instr_valid_reg <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        ST_HOLD: begin
          if (redirect || instr_ready) begin
            instr_valid_reg <= 1'b0;
            state_reg       <= ST_FETCH;
            if (redirect) begin
              pc_reg <= target;
            end
          end
        end
        default: begin
          state_reg <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning address/PC width (legal: 32 or 64).
REQ-002 SHALL have parameter RESET_PC, default 0, meaning PC fetched first after reset.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning max wait cycles for imem_ack (1..255).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_req  out  1  instruction memory request.
REQ-007 SHALL have port imem_addr  out  WIDTH  request address.
REQ-008 SHALL have port imem_ack  in  1  one-cycle completion pulse; imem_rdata valid in the same cycle.
REQ-009 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-010 SHALL have port instr  out  32  held instruction.
REQ-011 SHALL have port instr_pc  out  WIDTH  PC of instr.
REQ-012 SHALL have port instr_valid  out  1  instr/instr_pc valid.
REQ-013 SHALL have port instr_ready  in  1  consumer accepts instr.
REQ-014 SHALL have port redirect  in  1  one-cycle request to change flow.
REQ-015 SHALL have port redir_kind  in  2  00 branch, 01 jump, 10 jump-register, 11 reserved (treated as 10).
REQ-016 SHALL have port redir_pc  in  WIDTH  PC of the redirecting instruction.
REQ-017 SHALL have port redir_imm  in  26  bits [15:0] branch offset, or [25:0] jump index.
REQ-018 SHALL have port redir_reg  in  WIDTH  jump-register target.
REQ-019 SHALL have port fetch_err  out  1  sticky timeout flag.

Function
REQ-020 SHALL implement FSM states FETCH, DRAIN, HOLD, ERR.
REQ-021 FETCH: imem_req=1, imem_addr=pc; both SHALL stay stable until imem_ack.
REQ-022 FETCH with ack and no redirect: capture imem_rdata into instr, pc into instr_pc, set instr_valid, set pc=pc+4, go to HOLD.
REQ-023 HOLD: imem_req=0; instr/instr_pc/instr_valid SHALL be held until instr_ready=1.
REQ-024 HOLD with instr_ready and no redirect: clear instr_valid, go to FETCH; throughput is therefore one instruction per (ack latency + 2) cycles minimum.
REQ-025 Branch target SHALL be redir_pc+4+(sign-extended redir_imm[15:0] shifted left 2), modulo 2^WIDTH.
REQ-026 Jump target SHALL be {(redir_pc+4)[WIDTH-1:28], redir_imm[25:0], 2'b00}.
REQ-027 Jump-register target SHALL be redir_reg unchanged.
REQ-028 Redirect SHALL take effect in the cycle it is sampled: pc=target, instr_valid cleared next cycle, whether or not instr_ready is also high.
REQ-029 Redirect in FETCH without ack: go to DRAIN; imem_req and imem_addr SHALL stay unchanged until ack; the acked data SHALL be discarded; then go to FETCH at target.
REQ-030 Redirect in FETCH coinciding with ack: discard the data and go straight to FETCH at target.
REQ-031 Redirect in DRAIN SHALL overwrite the pending target (last redirect wins).
REQ-032 Redirect in HOLD SHALL go to FETCH at target.
REQ-033 A wait counter SHALL count FETCH/DRAIN cycles without ack; it resets on ack or on state entry.
REQ-034 Reaching TIMEOUT cycles without ack: go to ERR; fetch_err=1, imem_req=0, instr_valid=0; ERR is exited only by reset.
REQ-035 Redirect and instr_ready in ERR SHALL be ignored.
REQ-036 PC increment SHALL wrap modulo 2^WIDTH without any flag.

Reset
REQ-037 Reset assertion SHALL asynchronously set state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_err=0, wait counter=0.
REQ-038 With reset asserted, imem_req SHALL be 0; the first request SHALL appear in the first cycle after deassertion.
REQ-039 Reset mid-request SHALL abandon the outstanding access; a late ack SHALL be ignored only if it arrives in the cycle of deassertion; the memory SHALL not ack a pre-reset request after that cycle.

Structure
REQ-040 The FSM state encoding and the redir_kind codes SHALL be placed in a shared package (cpu_pkg), for reuse by the control state machine.
REQ-041 Target calculation (REQ-025..027) SHALL be a combinational sub-module, branch_target_calc, parametrised by WIDTH.
REQ-042 No memory SHALL be instantiated inside; instruction memory is external.

Verification
REQ-043 Reset, memory acking after 2 cycles, instr_ready=1 -> addresses 0,4,8 in order; instr_valid pulses each with the correct instr_pc.
REQ-044 Hold instr_ready=0 for 5 cycles -> instr stable, imem_req=0, no address advance; after ready, the next fetch is at +4.
REQ-045 Branch redirect with redir_pc=0x100, imm=0xFFFE -> next fetch at 0xFC; imm=0x0003 -> 0x110.
REQ-046 Jump with redir_pc=0xF0000010, imm=0x0000040 -> next fetch at 0xF0000100; jr with redir_reg=0x2000 -> 0x2000.
REQ-047 Redirect during FETCH, ack 3 cycles later -> the acked word never appears on instr; the next imem_addr is the target.
REQ-048 With TIMEOUT=4 and no ack -> fetch_err=1 after 4 wait cycles, imem_req=0; redirect is ignored until reset_n pulses low.
